// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the TX and RX paths.
// Holds the FSM state encoding, the line-level constants and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Odd parity is the inverse of the data XOR, so the type bit can be XORed in directly.
  function automatic logic f_parity(input logic i_xor, input logic i_typ);
    return i_xor ^ (i_typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Data-phase shifter for the UART transmitter: holds the word, counts bits sent,
// and flags the last data bit so the FSM can leave the DATA state.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_shift,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_bit,
  output logic                  o_next_bit,
  output logic                  o_done
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_M1 = CW'(DATA_WIDTH - 2);

  logic [DATA_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_cnt;
  logic                  r_done;

  // r_cnt is the index of the data bit currently on the line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_cnt   <= '0;
      r_done  <= (DATA_WIDTH == 1);
    end else if (i_shift) begin
      r_shift <= r_shift >> 1;
      r_cnt   <= r_cnt + 1'b1;
      r_done  <= (r_cnt == LAST_M1);
    end
  end

  assign o_bit      = r_shift[0];
  assign o_next_bit = r_shift[1];
  assign o_done     = r_done;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start | data LSB-first | optional parity | stop bits, one bit per clk.
// Frame FSM, parity generation and registered line driver; the shifter lives in uart_tx_serializer.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_ready,
  output logic                  busy,
  output logic                  tx_out
);

  localparam logic STOP_INIT = logic'(STOP_BITS - 1);

  uart_state_e r_state;
  logic        r_tx;
  logic        r_busy;
  logic        r_par_en;
  logic        r_par_bit;
  logic        r_stop_cnt;

  logic w_last_stop;
  logic w_accept;
  logic w_shift;
  logic w_ser_bit;
  logic w_ser_next;
  logic w_ser_done;

  assign w_last_stop = (r_stop_cnt == 1'b0);
  assign tx_ready    = (r_state == IDLE) | ((r_state == STOP) & w_last_stop);
  assign w_accept    = data_valid & tx_ready;
  assign w_shift     = (r_state == DATA) & ~w_ser_done;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_shift    (w_shift),
    .i_data     (p_data),
    .o_bit      (w_ser_bit),
    .o_next_bit (w_ser_next),
    .o_done     (w_ser_done)
  );

  // Accept is only possible in IDLE or on the last stop bit, so it is handled ahead of the case.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_tx       <= STOP_BIT;
      r_busy     <= 1'b0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop_cnt <= 1'b0;
    end else if (w_accept) begin
      r_state   <= START;
      r_tx      <= START_BIT;
      r_busy    <= 1'b1;
      r_par_en  <= par_en;
      r_par_bit <= f_parity(^p_data, par_typ);
    end else begin
      case (r_state)
        IDLE: begin
          r_tx   <= STOP_BIT;
          r_busy <= 1'b0;
        end
        START: begin
          r_state <= DATA;
          r_tx    <= w_ser_bit;
        end
        DATA: begin
          if (!w_ser_done) begin
            r_tx <= w_ser_next;
          end else if (r_par_en) begin
            r_state <= PARITY;
            r_tx    <= r_par_bit;
          end else begin
            r_state    <= STOP;
            r_tx       <= STOP_BIT;
            r_stop_cnt <= STOP_INIT;
          end
        end
        PARITY: begin
          r_state    <= STOP;
          r_tx       <= STOP_BIT;
          r_stop_cnt <= STOP_INIT;
        end
        STOP: begin
          if (!w_last_stop) begin
            r_stop_cnt <= r_stop_cnt - 1'b1;
          end else begin
            r_state <= IDLE;
            r_tx    <= STOP_BIT;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= STOP_BIT;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign tx_out = r_tx;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: two instances (1 and 2 stop bits), a frame-level bit-stream
// reference model, directed frames from the datasheet examples plus randomized traffic.
module tb_uart_tx_frame;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0][7:0] p_data;
  logic [1:0]      data_valid;
  logic [1:0]      par_en;
  logic [1:0]      par_typ;
  logic [1:0]      tx_ready;
  logic [1:0]      busy;
  logic [1:0]      tx_out;

  uart_tx_frame #(.DATA_WIDTH(8), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .p_data(p_data[0]), .data_valid(data_valid[0]),
    .par_en(par_en[0]), .par_typ(par_typ[0]), .tx_ready(tx_ready[0]),
    .busy(busy[0]), .tx_out(tx_out[0])
  );

  uart_tx_frame #(.DATA_WIDTH(8), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst), .p_data(p_data[1]), .data_valid(data_valid[1]),
    .par_en(par_en[1]), .par_typ(par_typ[1]), .tx_ready(tx_ready[1]),
    .busy(busy[1]), .tx_out(tx_out[1])
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: each accepted word becomes a whole frame bit vector; the line walks it.
  logic [15:0] mframe [2];
  int          mlen   [2] = '{0, 0};
  int          mpos   [2] = '{0, 0};
  logic        mcur   [2] = '{1'b1, 1'b1};
  logic        mbusy  [2] = '{1'b0, 1'b0};
  int          acc_cnt[2] = '{0, 0};

  function automatic logic [15:0] build_frame(input logic [7:0] d, input logic pe, input logic pt);
    logic [15:0] f;
    int ones;
    f = '1;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[1+i] = d[i];
      if (d[i]) ones++;
    end
    if (pe) f[9] = ((ones % 2) == 1) ? ~pt : pt;
    return f;
  endfunction

  function automatic logic m_ready(input int k);
    return !mbusy[k] || (mpos[k] == mlen[k] - 1);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        mbusy[k] <= 1'b0;
        mcur[k]  <= 1'b1;
      end else if (data_valid[k] && m_ready(k)) begin
        mframe[k]  <= build_frame(p_data[k], par_en[k], par_typ[k]);
        mlen[k]    <= 9 + int'(par_en[k]) + (k + 1);
        mpos[k]    <= 0;
        mcur[k]    <= 1'b0;
        mbusy[k]   <= 1'b1;
        acc_cnt[k] <= acc_cnt[k] + 1;
      end else if (mbusy[k] && mpos[k] < mlen[k] - 1) begin
        mpos[k] <= mpos[k] + 1;
        mcur[k] <= mframe[k][mpos[k]+1];
      end else begin
        mbusy[k] <= 1'b0;
        mcur[k]  <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("tx_out%0d", k), tx_out[k], mcur[k]);
        chk($sformatf("busy%0d", k), busy[k], mbusy[k]);
        chk($sformatf("tx_ready%0d", k), tx_ready[k], m_ready(k));
      end
    end
  end

  // Present a word and hold it until the model sees it accepted; optionally keep valid high.
  task automatic send(input int k, input logic [7:0] d, input logic pe, input logic pt, input bit hold);
    int c0;
    int n;
    c0 = acc_cnt[k];
    p_data[k] = d;
    par_en[k] = pe;
    par_typ[k] = pt;
    data_valid[k] = 1'b1;
    n = 0;
    while (acc_cnt[k] == c0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (acc_cnt[k] == c0) chk("accept_timeout", acc_cnt[k] - c0, 1);
    if (!hold) begin
      data_valid[k] = 1'b0;
      p_data[k] = 8'($urandom);
      par_en[k] = 1'($urandom);
      par_typ[k] = 1'($urandom);
    end
  endtask

  task automatic cap_frame(input int k, input int n, output logic [31:0] cap);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      cap = {cap[30:0], tx_out[k]};
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] cap;
  logic [31:0] cap2;

  initial begin
    rst = 1'b0;
    p_data = '0;
    data_valid = '0;
    par_en = '0;
    par_typ = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tx", tx_out, 2'b11);
    chk("reset_busy", busy, 2'b00);
    chk("reset_ready", tx_ready, 2'b11);
    chk_en = 1'b1;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    send(0, 8'hA5, 1'b0, 1'b0, 1'b0);
    cap_frame(0, 10, cap);
    chk("a5_noparity", cap, 32'b0101001011);
    chk("a5_idle_busy", busy[0], 1'b0);

    send(0, 8'hA5, 1'b1, 1'b0, 1'b0);
    cap_frame(0, 11, cap);
    chk("a5_even", cap, 32'b01010010101);
    send(0, 8'hA5, 1'b1, 1'b1, 1'b0);
    cap_frame(0, 11, cap);
    chk("a5_odd", cap, 32'b01010010111);

    send(0, 8'h07, 1'b1, 1'b0, 1'b0);
    cap_frame(0, 11, cap);
    chk("x07_even", cap, 32'b01110000011);

    send(0, 8'h55, 1'b0, 1'b0, 1'b1);
    fork
      cap_frame(0, 20, cap);
      send(0, 8'h0F, 1'b0, 1'b0, 1'b0);
    join
    chk("b2b_55_0f", cap, 32'b01010101010111100001);

    send(1, 8'hFF, 1'b1, 1'b1, 1'b0);
    fork
      cap_frame(1, 12, cap2);
      begin
        repeat (3) begin @(posedge clk); #1; end
        send(1, 8'h3C, 1'b0, 1'b0, 1'b0);
      end
    join
    chk("ff_odd_2stop", cap2, 32'b011111111111);
    repeat (14) begin @(posedge clk); #1; end

    send(0, 8'h3C, 1'b1, 1'b0, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("midrst_tx", tx_out[0], 1'b1);
    chk("midrst_busy", busy[0], 1'b0);
    chk("midrst_ready", tx_ready[0], 1'b1);
    rst = 1'b1;
    cap_frame(0, 12, cap);
    chk("midrst_quiet", cap, 32'hFFF);

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 40; i++) begin
        logic [7:0] d;
        logic pe;
        logic pt;
        bit hold;
        d = 8'($urandom);
        pe = 1'($urandom);
        pt = 1'($urandom);
        hold = ($urandom_range(0, 3) == 0);
        send(k, d, pe, pt, hold);
        if (!hold) begin
          repeat ($urandom_range(0, 12)) begin @(posedge clk); #1; end
        end
      end
      data_valid[k] = 1'b0;
      repeat (16) begin @(posedge clk); #1; end
    end

    repeat (10) begin @(posedge clk); #1; end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
